// File: rtl/bitstream_feeder_pkg.sv
// Shared definitions for the bitstream feeder: FSM encoding, header layout
// and the Decoder command codes.
package bitstream_feeder_pkg;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_HDR     = 2'd1;
  localparam logic [1:0] STATE_PAYLOAD = 2'd2;
  localparam logic [1:0] STATE_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = STATE_IDLE,
    HDR     = STATE_HDR,
    PAYLOAD = STATE_PAYLOAD,
    DONE    = STATE_DONE
  } feeder_state_t;

  localparam int HEADER_BYTES  = 5;
  localparam int COMMAND_BYTES = 2;
  localparam int LENGTH_BYTES  = 3;

  localparam logic [15:0] CMD_A010 = 16'hA010;
  localparam logic [15:0] CMD_A020 = 16'hA020;
  localparam logic [15:0] CMD_A030 = 16'hA030;
  localparam logic [15:0] CMD_A040 = 16'hA040;
  localparam logic [15:0] CMD_A050 = 16'hA050;
  localparam logic [15:0] CMD_A060 = 16'hA060;

endpackage

// File: rtl/feeder_byte_fifo.sv
// Byte FIFO between the host link and the frame parser. Show-ahead read:
// dout always presents the head entry while the FIFO is not empty.
module feeder_byte_fifo #(
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BYTE_WIDTH-1:0] din,
  output logic [BYTE_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [BYTE_WIDTH-1:0]    mem [FIFO_DEPTH];
  // Extra MSB on each pointer separates the full and empty cases.
  logic [FIFO_ADDR_WIDTH:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                 (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign dout  = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];

  // Pointer update; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/bitstream_feeder.sv
// Bitstream feeder: buffers host bytes, strips the 5-byte frame header
// (command, payload length) and serializes the payload MSB-first to the
// Decoder at up to one bit per cycle.
//
//   state   | meaning
//   IDLE    | waiting for the first header byte of a frame
//   HDR     | popping the 5 header bytes (command, then length)
//   PAYLOAD | loading payload bytes and shifting out bits
//   DONE    | frame complete, pulse stream_done
module bitstream_feeder #(
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH      = 8,
  parameter int COMMAND_WIDTH   = 16,
  parameter int LENGTH_WIDTH    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     hold,
  output logic                     stream_bit,
  output logic                     is_new,
  output logic [COMMAND_WIDTH-1:0] command,
  output logic                     command_valid,
  output logic                     stream_done,
  output logic                     busy
);
  import bitstream_feeder_pkg::*;

  localparam int BCW = $clog2(BYTE_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BYTE_WIDTH - 1);

  feeder_state_t state;
  logic [2:0]    hdr_cnt;
  logic [COMMAND_WIDTH-1:0]           cmd_sh;
  logic [LENGTH_WIDTH-BYTE_WIDTH-1:0] len_sh;
  logic [LENGTH_WIDTH-1:0]            len_next;
  logic [LENGTH_WIDTH-1:0]            rem;
  logic [BYTE_WIDTH-1:0]              sr;
  logic                               sr_valid;
  logic [BCW-1:0]                     bit_cnt;
  logic                               last_bit;

  logic                  push;
  logic                  pop;
  logic [BYTE_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign s_ready  = !fifo_full;
  assign push     = s_valid && !fifo_full;
  assign busy     = (state != IDLE);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign len_next = {len_sh, fifo_dout};

  feeder_byte_fifo #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .BYTE_WIDTH      (BYTE_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop decision: one header byte per cycle, or a payload byte when the shift
  // register is empty or is emitting its last bit with more bytes still due.
  always_comb begin
    pop = 1'b0;
    case (state)
      HDR:     pop = !fifo_empty;
      PAYLOAD: begin
        if (!hold) begin
          if (sr_valid) pop = last_bit && (rem > LENGTH_WIDTH'(1)) && !fifo_empty;
          else          pop = !fifo_empty;
        end
      end
      default: pop = 1'b0;
    endcase
  end

  // Frame sequencing, header capture and payload serialization.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      hdr_cnt       <= '0;
      cmd_sh        <= '0;
      len_sh        <= '0;
      rem           <= '0;
      sr            <= '0;
      sr_valid      <= 1'b0;
      bit_cnt       <= '0;
      stream_bit    <= 1'b0;
      is_new        <= 1'b0;
      command       <= '0;
      command_valid <= 1'b0;
      stream_done   <= 1'b0;
    end else begin
      is_new      <= 1'b0;
      stream_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state         <= HDR;
            command_valid <= 1'b0;
            hdr_cnt       <= '0;
          end
        end
        HDR: begin
          if (!fifo_empty) begin
            if (hdr_cnt < 3'(COMMAND_BYTES))
              cmd_sh <= {cmd_sh[COMMAND_WIDTH-BYTE_WIDTH-1:0], fifo_dout};
            else
              len_sh <= len_next[LENGTH_WIDTH-BYTE_WIDTH-1:0];
            if (hdr_cnt == 3'(HEADER_BYTES - 1)) begin
              command       <= cmd_sh;
              command_valid <= 1'b1;
              rem           <= len_next;
              sr_valid      <= 1'b0;
              bit_cnt       <= '0;
              hdr_cnt       <= '0;
              state         <= (len_next == '0) ? DONE : PAYLOAD;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (!hold) begin
            if (sr_valid) begin
              stream_bit <= sr[BYTE_WIDTH-1];
              is_new     <= 1'b1;
              sr         <= sr << 1;
              bit_cnt    <= bit_cnt + 1'b1;
              if (last_bit) begin
                rem     <= rem - 1'b1;
                bit_cnt <= '0;
                if (rem == LENGTH_WIDTH'(1)) begin
                  state    <= DONE;
                  sr_valid <= 1'b0;
                end else if (pop) begin
                  // Back-to-back reload keeps the bit stream gap-free.
                  sr <= fifo_dout;
                end else begin
                  sr_valid <= 1'b0;
                end
              end
            end else if (pop) begin
              sr       <= fifo_dout;
              sr_valid <= 1'b1;
              bit_cnt  <= '0;
            end
          end
        end
        DONE: begin
          stream_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_feeder.sv
// Directed bench for bitstream_feeder: a host-side byte queue feeds the DUT,
// expected payload bits are queued at send time and popped on each is_new.
module tb_bitstream_feeder;
  import bitstream_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        hold = 1'b0;
  logic        stream_bit;
  logic        is_new;
  logic [15:0] command;
  logic        command_valid;
  logic        stream_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] host_q[$];
  logic       exp_q[$];

  int   cyc = 0, new_count = 0, first_new = 0, last_new = 0, max_gap = 0;
  int   done_cnt = 0, done_cyc = 0, cv_rise = 0;
  logic cv_prev = 1'b0;

  bitstream_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .hold          (hold),
    .stream_bit    (stream_bit),
    .is_new        (is_new),
    .command       (command),
    .command_valid (command_valid),
    .stream_done   (stream_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Host link model: presents the head of host_q, retires it once accepted.
  initial begin
    logic accept;
    forever begin
      @(negedge clk);
      accept = s_valid && s_ready && rst;
      @(posedge clk);
      #1;
      if (accept && host_q.size() > 0) void'(host_q.pop_front());
      if (host_q.size() > 0) begin
        s_valid = 1'b1;
        s_data  = host_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Output monitor: scoreboard compare on every is_new plus timing stats.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (is_new === 1'b1) begin
        if (new_count > 0 && cyc - last_new > max_gap) max_gap = cyc - last_new;
        if (new_count == 0) first_new = cyc;
        last_new = cyc;
        new_count++;
        if (exp_q.size() == 0) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL extra_bit: observed bit %0b, expected no bit", stream_bit);
          end
        end else begin
          check("payload_bit", 32'(stream_bit), 32'(exp_q.pop_front()));
        end
      end
      if (stream_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_excl_new", 32'(is_new), 32'd0);
      end
      if (command_valid === 1'b1 && !cv_prev) cv_rise = cyc;
      cv_prev = (command_valid === 1'b1);
    end
  end

  task automatic clear_stats();
    new_count = 0;
    max_gap   = 0;
    done_cnt  = 0;
  endtask

  task automatic send_header(input logic [15:0] cmd, input logic [23:0] len);
    host_q.push_back(cmd[15:8]);
    host_q.push_back(cmd[7:0]);
    host_q.push_back(len[23:16]);
    host_q.push_back(len[15:8]);
    host_q.push_back(len[7:0]);
  endtask

  task automatic send_payload(input logic [7:0] b);
    host_q.push_back(b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic send_frame(input logic [15:0] cmd, input logic [7:0] pl[$]);
    send_header(cmd, 24'(pl.size()));
    foreach (pl[i]) send_payload(pl[i]);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (new_count < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    assert (new_count >= n) else begin
      errors++;
      $error("FAIL wait_bits: observed %0d bits, expected %0d within %0d cycles", new_count, n, budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    int n0 = done_cnt;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    assert (done_cnt > n0) else begin
      errors++;
      $error("FAIL wait_done: observed no stream_done, expected one within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_is_new"}, 32'(is_new), 32'd0);
    check({tag, "_bit"}, 32'(stream_bit), 32'd0);
    check({tag, "_command"}, 32'(command), 32'd0);
    check({tag, "_cmd_valid"}, 32'(command_valid), 32'd0);
    check({tag, "_done"}, 32'(stream_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    // Frame A050, payload C3 5A, gap-free
    clear_stats();
    pl = '{8'hC3, 8'h5A};
    send_frame(CMD_A050, pl);
    wait_done(200);
    check("t1_command", 32'(command), 32'(CMD_A050));
    check("t1_cmd_valid", 32'(command_valid), 32'd1);
    check("t1_bits", 32'(new_count), 32'd16);
    check("t1_span", 32'(last_new - first_new), 32'd15);
    check("t1_done_lat", 32'(done_cyc - last_new), 32'd1);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_exp_left", 32'(exp_q.size()), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // Zero-length frame A010
    clear_stats();
    pl = {};
    send_frame(CMD_A010, pl);
    wait_done(200);
    check("t2_command", 32'(command), 32'(CMD_A010));
    check("t2_bits", 32'(new_count), 32'd0);
    check("t2_done_lat", 32'(done_cyc - cv_rise), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);

    // Fill the FIFO under hold, then release
    clear_stats();
    hold = 1'b1;
    pl = {};
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom_range(255)));
    send_frame(CMD_A020, pl);
    repeat (40) @(negedge clk);
    #1;
    check("t3_s_ready_full", 32'(s_ready), 32'd0);
    check("t3_host_left", 32'(host_q.size()), 32'd4);
    check("t3_held_bits", 32'(new_count), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    hold = 1'b0;
    wait_done(400);
    check("t3_bits", 32'(new_count), 32'd160);
    check("t3_span", 32'(last_new - first_new), 32'd159);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_exp_left", 32'(exp_q.size()), 32'd0);

    // Hold for 3 cycles in the middle of a byte
    clear_stats();
    pl = '{8'hFF, 8'h00};
    send_frame(CMD_A040, pl);
    wait_bits(3, 100);
    @(posedge clk); #1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (i == 2) begin
        #1;
        hold = 1'b0;
      end
      @(negedge clk);
      check("t4_hold_is_new", 32'(is_new), 32'd0);
    end
    wait_done(200);
    check("t4_command", 32'(command), 32'(CMD_A040));
    check("t4_bits", 32'(new_count), 32'd16);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_exp_left", 32'(exp_q.size()), 32'd0);

    // Underrun: second payload byte arrives late
    clear_stats();
    send_header(CMD_A060, 24'd2);
    send_payload(8'h96);
    wait_bits(8, 100);
    repeat (5) @(posedge clk);
    #1;
    send_payload(8'hA5);
    wait_done(200);
    check("t5_gap_ge6", 32'(max_gap >= 6), 32'd1);
    check("t5_bits", 32'(new_count), 32'd16);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_exp_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a 4-byte payload, then a fresh frame
    clear_stats();
    pl = '{8'h3C, 8'hE7, 8'h12, 8'h9B};
    send_frame(16'h1234, pl);
    wait_bits(10, 200);
    @(posedge clk); #1;
    rst = 1'b0;
    host_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    clear_stats();
    @(negedge clk);
    check_reset_outputs("t6_rst");
    @(posedge clk); #1;
    pl = '{8'h81};
    send_frame(CMD_A030, pl);
    wait_done(200);
    check("t6_command", 32'(command), 32'(CMD_A030));
    check("t6_bits", 32'(new_count), 32'd8);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check("t6_exp_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_feeder.md
Name: bitstream_feeder

Overview:
Upstream stage of the Decoder top level. Accepts framed encoded-image bytes from the host link over a valid/ready byte interface and buffers them in a small FIFO. Strips a 5-byte frame header (16-bit command, 24-bit payload byte count) and drives the Decoder's command input. Serializes the payload MSB-first onto the Decoder's bit/is_new inputs, at most one bit per cycle.

Parameters:
FIFO_DEPTH, 16, byte FIFO entries (power of two)
FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH)
BYTE_WIDTH, 8, host byte width
COMMAND_WIDTH, 16, command field width (2 header bytes)
LENGTH_WIDTH, 24, payload byte-count width (3 header bytes)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-low
s_data  input  BYTE_WIDTH  host byte
s_valid  input  1  host byte valid
s_ready  output  1  FIFO can accept; equals !fifo_full
hold  input  1  pauses serialization while high
bit  output  1  serialized payload bit, to Decoder bit
is_new  output  1  one-cycle strobe: bit is valid this cycle
command  output  COMMAND_WIDTH  latched frame command, to Decoder command
command_valid  output  1  high from header capture until the next frame header starts
stream_done  output  1  one-cycle pulse after the last payload bit
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst==0 at a clk edge): FIFO emptied, state=IDLE, bit=0, is_new=0, command=0, command_valid=0, stream_done=0, busy=0, internal counters=0. s_ready=1 in the cycle after reset. Reset mid-frame discards all buffered and partially shifted data. No residual bits are emitted.
- FIFO: a push occurs on s_valid&&s_ready. A pop occurs only when the FSM consumes a byte. Simultaneous push and pop while full is not possible (s_ready=0). Simultaneous push and pop while empty is not allowed: a pop requires !empty in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, HDR, PAYLOAD, DONE.
- IDLE: if the FIFO is not empty, go to HDR. command_valid drops to 0 on this transition.
- HDR: pops one byte per cycle while the FIFO is not empty. hdr_cnt counts 0..4.
  - Bytes 0-1 form command, big-endian.
  - Bytes 2-4 form len, big-endian.
  - On the cycle after byte 4 is popped: command is registered and command_valid=1.
  - If len==0, go to DONE. Otherwise go to PAYLOAD.
- PAYLOAD:
  - 8-bit shift register sr plus bit_cnt (0..7), and remaining byte count rem (initialised from len).
  - When sr is empty and the FIFO is not empty and hold==0: pop a byte into sr.
  - On each following cycle with hold==0: bit<=sr[7], is_new<=1, sr shifts left, bit_cnt increments.
  - On the cycle that emits bit_cnt==7: if rem>1 and the FIFO is not empty, pop the next byte in the same cycle. Sustained throughput is therefore 1 bit/cycle with no bubble.
  - FIFO underrun mid-payload: is_new=0 until a byte arrives. The stream is not aborted.
  - hold==1: is_new=0 and sr, bit_cnt and rem are frozen. bit keeps its last value.
  - After the 8th bit of the last byte (rem==1), go to DONE.
- Latency: the first payload bit appears on is_new 2 cycles after the payload byte reaches the FIFO head, with hold==0.
- DONE: stream_done=1 for exactly one cycle, then IDLE. command and command_valid are retained.
- Back-to-back frames: header bytes of the next frame may already sit in the FIFO. IDLE leaves on the next cycle.
- Arithmetic: rem is LENGTH_WIDTH wide and decrements once per fully emitted byte. It never underflows because DONE is taken at rem==1 after bit 7.
- is_new and stream_done are never high in the same cycle.

Decomposition:
- Shared package bitstream_feeder_pkg:
  - state encoding localparams (IDLE=0, HDR=1, PAYLOAD=2, DONE=3)
  - HEADER_BYTES=5
  - COMMAND byte count = 2
  - LENGTH byte count = 3
  - the Decoder command codes A010..A060, for benches
- One sub-module, feeder_byte_fifo: synchronous FIFO with parameters FIFO_DEPTH/BYTE_WIDTH. Ports: push, pop, din, dout (show-ahead), full, empty.

Test Plan:
- Frame A050 / len=2 / payload C3,5A, hold=0, continuous s_valid -> command=16'hA050 with command_valid=1; 16 consecutive is_new pulses carrying bits 1100001101011010; one stream_done pulse the cycle after the last bit.
- Frame A010 with len=0 -> command=A010, no is_new pulses, stream_done 1 cycle after command_valid rises, then busy=0.
- Push 20 bytes without gaps while hold=1 -> s_ready=0 once 16 bytes are buffered; no byte lost after release. Emitted payload matches input order.
- hold toggled 1 for 3 cycles mid-byte during payload FF,00 -> is_new=0 in the hold cycles; emitted sequence is still 11111111 00000000.
- Payload byte supplied 5 cycles late (underrun) -> is_new gap of at least 5 cycles, then resume with correct bits; rem correct, single stream_done.
- rst=0 asserted after 10 payload bits of a 4-byte frame, then a new frame A030/len=1/81 -> after reset all outputs are 0; new frame emits 10000001 only, command=A030.
